branch_pred_ctrl: RTL and testbench
===================================

Name: branch_pred_ctrl

Overview:
- Branch prediction and misprediction-recovery controller for the 5-stage pipeline.
- IF stage: provides a taken/not-taken prediction from a table of 2-bit saturating counters (BHT).
- EX stage: takes the resolved branch outcome from the branch comparator, trains the BHT, detects mispredictions, and sequences the PC redirect and pipeline flush.
- Keeps performance counters for resolved branches and mispredictions.

Parameters:
- IDX_W, 4: BHT index width. The table has 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- XLEN, 32: PC width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF-stage PC is valid
- if_pc  in  XLEN  IF-stage PC
- pred_taken  out  1  prediction for if_pc; combinational
- stall  in  1  pipeline freeze; EX contents are held
- ex_valid  in  1  EX-stage instruction is valid
- ex_br_type  in  3  0 none, 1 beq, 2 blt, 3 bne, 4 bge, 5 bltu, 6 bgeu, 7 reserved
- ex_br  in  1  comparator result for ex_br_type
- ex_jump  in  1  unconditional jump (jal/jalr) in EX
- ex_pred_taken  in  1  prediction carried down the pipe with the EX instruction
- ex_pc  in  XLEN  PC of the EX instruction
- ex_target  in  XLEN  computed taken target
- redirect  out  1  load PC from redirect_pc
- redirect_pc  out  XLEN  correct next PC
- flush_if_id  out  1  kill the IF/ID register
- flush_id_ex  out  1  kill the ID/EX register
- branch_cnt  out  32  number of resolved conditional branches
- mispredict_cnt  out  32  number of mispredicted branches and jumps

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - redirect, flush_if_id, flush_id_ex = 0; redirect_pc = 0.
  - Both counters = 0.
  - Every BHT entry = 2'b01 (weakly not-taken).
  - Reset takes effect immediately, including mid-REDIRECT.
- Prediction:
  - pred_taken = if_valid & BHT[if_pc[IDX_W+1:2]][1]. Purely combinational.
  - No bypass: a same-cycle update to the same index is not visible until the next cycle.
- Resolution event (evt): ex_valid & !stall & state==IDLE & (ex_br_type in 1..6 | ex_jump).
  - ex_br_type=7 or 0 without ex_jump is not a branch: no update, no count.
  - If both ex_jump and ex_br_type!=0 are asserted, ex_jump wins: taken=1, no BHT update.
- Outcome: actual = ex_jump ? 1 : ex_br. mispredict = evt & (actual != ex_pred_taken).
- BHT training on evt with a conditional branch (not jump), at index ex_pc[IDX_W+1:2]:
  - actual=1: increment, saturating at 2'b11.
  - actual=0: decrement, saturating at 2'b00.
  - Counters never wrap.
- Counters:
  - branch_cnt += 1 on each conditional evt.
  - mispredict_cnt += 1 on each mispredict.
  - Both wrap modulo 2^32.
- FSM, states IDLE and REDIRECT:
  - IDLE -> REDIRECT on the clock edge where mispredict=1. On that edge:
    - redirect_pc <= actual ? ex_target : ex_pc + 4, truncated to XLEN.
    - redirect, flush_if_id, flush_id_ex <= 1.
  - Latency is 1 cycle: the outputs assert in the cycle after EX resolution.
  - REDIRECT with stall=1: stay in REDIRECT; outputs and redirect_pc are held.
  - REDIRECT with stall=0: -> IDLE; outputs go to 0 on that edge. The pulse lasts exactly one unstalled cycle.
  - In REDIRECT, the EX instruction is wrong-path: ex_valid is ignored, with no training and no counting.
  - Correct predictions cause no redirect and no flush.
- Stall in IDLE: no evt. The held EX instruction is resolved exactly once, on its first unstalled cycle.

Test Plan:
- Reset check: assert rst_n=0 mid-run, then release. -> All outputs 0; pred_taken=0 for if_pc=0x100, 0x13C, 0xFFFC.
- Taken beq mispredicted:
  - Stimulus: ex_pc=0x100, ex_br_type=1, ex_br=1, ex_pred_taken=0, ex_target=0x200.
  - Next cycle: redirect=1, redirect_pc=0x200, both flushes=1.
  - Counts: mispredict_cnt=1, branch_cnt=1.
  - Following cycle: redirect=0; pred_taken for if_pc=0x100 is 1 (counter 2'b10).
- Saturation: three more correctly predicted taken branches at 0x100. -> No redirect; counter stays at 2'b11; branch_cnt=4, mispredict_cnt=1.
- Not-taken mispredict:
  - Stimulus: ex_pc=0x104, ex_br_type=5, ex_br=0, ex_pred_taken=1.
  - Required: redirect_pc=0x108; entry 1 decrements from 2'b01 to 2'b00, then stays 00 on a second not-taken.
- Stall during REDIRECT:
  - Stimulus: after a mispredict, hold stall=1 for 3 cycles with ex_valid=1 and a taken branch in EX.
  - Required: redirect held high for 4 cycles total; BHT unchanged and counts unchanged by the wrong-path EX instruction.
- Jump and reserved type:
  - ex_jump=1, ex_pred_taken=0, ex_target=0x400 -> redirect_pc=0x400; no BHT change; branch_cnt unchanged.
  - ex_br_type=7 -> no effect.

Source files
------------

// File: rtl/branch_pred_ctrl.sv
// Branch predictor (2-bit saturating BHT) with EX-stage misprediction detection,
// one-cycle PC redirect / pipeline flush sequencing and branch performance counters.
module branch_pred_ctrl #(
    parameter int IDX_W = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic [2:0]      ex_br_type,
    input  logic            ex_br,
    input  logic            ex_jump,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispredict_cnt
);
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t                    state;
    logic [ENTRIES-1:0][1:0]   bht;
    logic [IDX_W-1:0]          if_idx;
    logic [IDX_W-1:0]          ex_idx;
    logic                      is_cond;
    logic                      evt;
    logic                      actual;
    logic                      mispredict;
    logic                      train;
    logic                      unused_bits;

    assign if_idx      = if_pc[IDX_W+1:2];
    assign ex_idx      = ex_pc[IDX_W+1:2];
    assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    // Table read sees only registered state, so same-cycle training is not bypassed.
    assign pred_taken = if_valid & bht[if_idx][1];

    assign is_cond    = (ex_br_type != 3'd0) && (ex_br_type != 3'd7);
    assign evt        = ex_valid & ~stall & (state == IDLE) & (is_cond | ex_jump);
    assign actual     = ex_jump | ex_br;
    assign mispredict = evt & (actual != ex_pred_taken);
    // Jumps win over any branch type and never train the table.
    assign train      = evt & is_cond & ~ex_jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bht <= {ENTRIES{2'b01}};
        end else if (train) begin
            if (actual && bht[ex_idx] != 2'b11)
                bht[ex_idx] <= bht[ex_idx] + 2'b01;
            else if (!actual && bht[ex_idx] != 2'b00)
                bht[ex_idx] <= bht[ex_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (train)      branch_cnt     <= branch_cnt + 32'd1;
            if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            redirect    <= 1'b0;
            flush_if_id <= 1'b0;
            flush_id_ex <= 1'b0;
            redirect_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state       <= REDIRECT;
                        redirect    <= 1'b1;
                        flush_if_id <= 1'b1;
                        flush_id_ex <= 1'b1;
                        redirect_pc <= actual ? ex_target : ex_pc + XLEN'(4);
                    end
                end
                REDIRECT: begin
                    // Pulse lasts until the pipeline actually advances once.
                    if (!stall) begin
                        state       <= IDLE;
                        redirect    <= 1'b0;
                        flush_if_id <= 1'b0;
                        flush_id_ex <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed table-driven bench for branch_pred_ctrl; expected values are hand-computed.
module tb_branch_pred_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b1;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_br_type = '0;
    logic        ex_br = 1'b0;
    logic        ex_jump = 1'b0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_target = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    branch_pred_ctrl #(.IDX_W(4), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .stall(stall), .ex_valid(ex_valid),
        .ex_br_type(ex_br_type), .ex_br(ex_br), .ex_jump(ex_jump),
        .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_target(ex_target),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, valid;
        logic [2:0]  typ;
        logic        br, jump, pred;
        logic [31:0] pc, tgt, ifpc;
        logic        e_red;
        logic [31:0] e_rpc, e_b, e_m;
        logic        e_pt;
    } vec_t;

    function automatic vec_t mk(logic st, logic va, logic [2:0] ty, logic br, logic jp,
                                logic pr, logic [31:0] pc, logic [31:0] tg, logic [31:0] ip,
                                logic rd, logic [31:0] rp, logic [31:0] b, logic [31:0] m,
                                logic pt);
        vec_t v;
        v.stall = st; v.valid = va; v.typ = ty; v.br = br; v.jump = jp; v.pred = pr;
        v.pc = pc; v.tgt = tg; v.ifpc = ip;
        v.e_red = rd; v.e_rpc = rp; v.e_b = b; v.e_m = m; v.e_pt = pt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic red, input logic [31:0] rpc,
                              input logic [31:0] b, input logic [31:0] m, input logic pt);
        chk("redirect", idx, 32'(redirect), 32'(red));
        chk("flush_if_id", idx, 32'(flush_if_id), 32'(red));
        chk("flush_id_ex", idx, 32'(flush_id_ex), 32'(red));
        chk("redirect_pc", idx, redirect_pc, rpc);
        chk("branch_cnt", idx, branch_cnt, b);
        chk("mispredict_cnt", idx, mispredict_cnt, m);
        chk("pred_taken", idx, 32'(pred_taken), 32'(pt));
    endtask

    task automatic apply(input int idx, input vec_t v);
        stall = v.stall; ex_valid = v.valid; ex_br_type = v.typ; ex_br = v.br;
        ex_jump = v.jump; ex_pred_taken = v.pred; ex_pc = v.pc; ex_target = v.tgt;
        if_pc = v.ifpc;
        @(posedge clk);
        #1;
        check_outs(idx, v.e_red, v.e_rpc, v.e_b, v.e_m, v.e_pt);
    endtask

    vec_t tbl[$];

    initial begin
        // stall valid typ br jump pred pc tgt ifpc | red rpc b m pt
        tbl.push_back(mk(0,0,0,0,0,0,'h000,'h000,'h100, 0,'h000, 0,0,0));
        tbl.push_back(mk(0,1,1,1,0,0,'h100,'h200,'h100, 1,'h200, 1,1,1));
        tbl.push_back(mk(0,1,1,1,0,0,'h100,'h200,'h100, 0,'h200, 1,1,1)); // wrong path ignored
        tbl.push_back(mk(0,1,1,1,0,1,'h100,'h200,'h100, 0,'h200, 2,1,1));
        tbl.push_back(mk(0,1,1,1,0,1,'h100,'h200,'h100, 0,'h200, 3,1,1));
        tbl.push_back(mk(0,1,1,1,0,1,'h100,'h200,'h100, 0,'h200, 4,1,1));
        tbl.push_back(mk(0,1,1,0,0,1,'h100,'h200,'h100, 1,'h104, 5,2,1)); // 11 -> 10
        tbl.push_back(mk(0,0,0,0,0,0,'h000,'h000,'h100, 0,'h104, 5,2,1));
        tbl.push_back(mk(0,1,1,0,0,1,'h100,'h200,'h100, 1,'h104, 6,3,0)); // 10 -> 01
        tbl.push_back(mk(0,0,0,0,0,0,'h000,'h000,'h104, 0,'h104, 6,3,0));
        tbl.push_back(mk(0,1,5,0,0,1,'h104,'h300,'h104, 1,'h108, 7,4,0)); // 01 -> 00
        tbl.push_back(mk(0,0,0,0,0,0,'h000,'h000,'h104, 0,'h108, 7,4,0));
        tbl.push_back(mk(0,1,5,0,0,0,'h104,'h300,'h104, 0,'h108, 8,4,0)); // stays 00
        tbl.push_back(mk(0,1,5,1,0,0,'h104,'h300,'h104, 1,'h300, 9,5,0)); // 00 -> 01
        tbl.push_back(mk(0,0,0,0,0,0,'h000,'h000,'h104, 0,'h300, 9,5,0));
        tbl.push_back(mk(0,1,5,1,0,0,'h104,'h300,'h104, 1,'h300,10,6,1)); // 01 -> 10
        tbl.push_back(mk(0,0,0,0,0,0,'h000,'h000,'h104, 0,'h300,10,6,1));
        tbl.push_back(mk(0,1,1,0,1,0,'h104,'h400,'h104, 1,'h400,10,7,1)); // jump wins
        tbl.push_back(mk(0,0,0,0,0,0,'h000,'h000,'h104, 0,'h400,10,7,1));
        tbl.push_back(mk(0,1,7,1,0,0,'h104,'h500,'h104, 0,'h400,10,7,1)); // reserved type
        tbl.push_back(mk(0,1,0,1,0,0,'h104,'h500,'h104, 0,'h400,10,7,1)); // not a branch
        tbl.push_back(mk(0,1,0,0,1,1,'h104,'h600,'h104, 0,'h400,10,7,1)); // correct jump
        tbl.push_back(mk(1,1,1,1,0,0,'h100,'h200,'h100, 0,'h400,10,7,0)); // stalled in IDLE
        tbl.push_back(mk(0,1,1,1,0,0,'h100,'h200,'h100, 1,'h200,11,8,1)); // resolved once
        tbl.push_back(mk(1,1,1,1,0,0,'h108,'h700,'h108, 1,'h200,11,8,0)); // REDIRECT held
        tbl.push_back(mk(1,1,1,1,0,0,'h108,'h700,'h108, 1,'h200,11,8,0));
        tbl.push_back(mk(1,1,1,1,0,0,'h108,'h700,'h108, 1,'h200,11,8,0));
        tbl.push_back(mk(0,1,1,1,0,0,'h108,'h700,'h108, 0,'h200,11,8,0)); // 4th cycle ends
        tbl.push_back(mk(0,1,1,1,0,0,'h100,'h200,'h100, 1,'h200,12,9,1));

        // Reset state at power-up
        #12;
        if_pc = 32'h100;
        #1;
        check_outs(-1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(i, tbl[i]);

        // if_valid gates the prediction
        if_valid = 1'b0;
        #1;
        chk("pred_gated", 100, 32'(pred_taken), 32'd0);
        if_valid = 1'b1;

        // Asynchronous reset while REDIRECT is active
        ex_valid = 1'b0; stall = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_outs(200, 0, 0, 0, 0, 0);
        if_pc = 32'h13C;
        #1;
        chk("pred_rst_13c", 201, 32'(pred_taken), 32'd0);
        if_pc = 32'hFFFC;
        #1;
        chk("pred_rst_fffc", 202, 32'(pred_taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(203, mk(0,0,0,0,0,0,'h000,'h000,'h100, 0,'h000, 0,0,0));
        apply(204, mk(0,1,3,1,0,1,'h100,'h200,'h100, 0,'h000, 1,0,1)); // bne taken, 01 -> 10

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
